ram_port_arbiter: RTL

Round-robin arbiter that shares port A of the dual-ported negedge-clocked `ram` between up to four requesters, such as fetch, data and debug/loader. It sits between the requesters and the RAM. Each cycle it picks one pending request and drives it onto the RAM port for exactly one cycle. It then returns read data one cycle later, tagged to the winning requester. Port B is left untouched for a separate owner.

---
 rtl/ram_port_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//
// Round-robin arbiter that shares port A of the dual-ported,
// negedge-clocked RAM between up to four requesters. Each cycle one
// eligible request is registered onto the RAM port for exactly one
// cycle. Read data returns one cycle later, tagged with a one-hot
// rsp_valid to the requester that issued it. Port B is not touched.
//
// Optional feature: define ARB_LOCK_EN to add the req_lock port. A
// winner that holds req_lock keeps exclusive access until it drops
// req_lock. This supports atomic read-modify-write.
//
// Parameters
//   wordsize  bits per RAM word
//   addrsize  RAM address bits
//   NREQ      number of requesters, legal range 2..4
//
// Ports
//   clock      system clock; all state updates on posedge
//   resetn     asynchronous active-low reset
//   req        per-requester request, held until its gnt bit
//   req_we     per-requester write (1) / read (0)
//   req_addr   flattened addresses, requester i at [i*addrsize +: addrsize]
//   req_wdat   flattened write data, same packing
//   req_lock   per-requester lock request (ARB_LOCK_EN only)
//   gnt        one-hot grant, one-cycle pulse
//   rsp_valid  one-hot read-data-valid pulse, one cycle after the read grant
//   rsp_dat    read data shared by all requesters; holds when rsp_valid=0
//   ram_addr   to addrA
//   ram_wen    to wEnA
//   ram_wdat   to wDatA
//   ram_ren    to rEnA
//   ram_rdat   from rDatA
module ram_port_arbiter #(
   parameter int wordsize = 8,
   parameter int addrsize = 9,
   parameter int NREQ     = 3
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_we,
   input  logic [NREQ*addrsize-1:0] req_addr,
   input  logic [NREQ*wordsize-1:0] req_wdat,
`ifdef ARB_LOCK_EN
   input  logic [NREQ-1:0]          req_lock,
`endif
   output logic [NREQ-1:0]          gnt,
   output logic [NREQ-1:0]          rsp_valid,
   output logic [wordsize-1:0]      rsp_dat,
   output logic [addrsize-1:0]      ram_addr,
   output logic                     ram_wen,
   output logic [wordsize-1:0]      ram_wdat,
   output logic                     ram_ren,
   input  logic [wordsize-1:0]      ram_rdat
);

   logic [1:0]          ptr_reg;
   logic [1:0]          ptr_next;
   logic [3:0]          elig;
   logic                have_win;
   logic [1:0]          win;
   logic [NREQ-1:0]     win_onehot;
   int                  cand;
   int                  nxt;

   logic [addrsize-1:0] addr_arr [NREQ];
   logic [wordsize-1:0] wdat_arr [NREQ];

   // Unpack the flattened request buses into per-requester arrays.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign addr_arr[gi] = req_addr[gi*addrsize +: addrsize];
         assign wdat_arr[gi] = req_wdat[gi*wordsize +: wordsize];
      end
   endgenerate

`ifdef ARB_LOCK_EN
   logic            locked_reg;
   logic [1:0]      owner_reg;
   logic            lock_active;
   logic [NREQ-1:0] owner_mask;

   // The lock is released on the first posedge where the owner's
   // req_lock is low, so arbitration in that cycle is already open.
   always_comb begin
      owner_mask            = '0;
      owner_mask[owner_reg] = 1'b1;
      lock_active           = locked_reg && req_lock[owner_reg];
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         locked_reg <= 1'b0;
         owner_reg  <= '0;
      end else begin
         if (have_win) begin
            locked_reg <= req_lock[win];
            owner_reg  <= win;
         end else begin
            locked_reg <= lock_active;
         end
      end
   end
`endif

   // Masking the requester granted last cycle prevents its still-held
   // request from being issued twice.
   always_comb begin
      elig           = '0;
      elig[NREQ-1:0] = req & ~gnt;
`ifdef ARB_LOCK_EN
      if (lock_active) begin
         elig[NREQ-1:0] = elig[NREQ-1:0] & owner_mask;
      end
`endif
   end

   // Search from ptr upward, modulo NREQ; the first eligible requester wins.
   always_comb begin
      have_win   = 1'b0;
      win        = '0;
      cand       = 0;
      nxt        = 0;
      win_onehot = '0;
      for (int off = 0; off < NREQ; off++) begin
         cand = (int'(ptr_reg) + off) % NREQ;
         if (!have_win && elig[cand]) begin
            have_win = 1'b1;
            win      = 2'(cand);
         end
      end
      if (have_win) begin
         win_onehot[win] = 1'b1;
         nxt             = (int'(win) + 1) % NREQ;
         ptr_next        = 2'(nxt);
      end else begin
         ptr_next        = ptr_reg;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ptr_reg   <= '0;
         gnt       <= '0;
         ram_addr  <= '0;
         ram_wdat  <= '0;
         ram_wen   <= 1'b0;
         ram_ren   <= 1'b0;
         rsp_valid <= '0;
         rsp_dat   <= '0;
      end else begin
         ptr_reg <= ptr_next;
         gnt     <= win_onehot;
         if (have_win) begin
            ram_addr <= addr_arr[win];
            ram_wdat <= wdat_arr[win];
            ram_wen  <= req_we[win];
            ram_ren  <= !req_we[win];
         end else begin
            ram_wen  <= 1'b0;
            ram_ren  <= 1'b0;
         end
         // gnt/ram_ren still describe the issue cycle here; the RAM
         // produced ram_rdat at the negedge inside that cycle.
         if (ram_ren) begin
            rsp_valid <= gnt;
            rsp_dat   <= ram_rdat;
         end else begin
            rsp_valid <= '0;
         end
      end
   end

endmodule
